// File: rtl/gaussian_pkg.sv
// Shared types and sizing for the gaussian write-side buffering.
package gaussian_pkg;
    localparam int HC_LINE_WIDTH  = 512;
    typedef logic [HC_LINE_WIDTH-1:0] t_hc_line;

    localparam int HC_WRBUF_DEPTH = 64;
    localparam int HC_WRBUF_AFULL = 48;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } t_wrbuf_state;
endpackage

// File: rtl/hc_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO; drops writes when full
// unless a read frees a slot in the same cycle.
module hc_sync_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         wrData,
    input  logic                     wrValid,
    input  logic                     rdReady,
    output logic [WIDTH-1:0]         rdData,
    output logic                     rdValid,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   nextCount,
    output logic                     pushed,
    output logic                     popped,
    output logic                     dropped
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wrPtr, rdPtr;

    assign rdValid = (count != '0);
    assign rdData  = mem[rdPtr];
    assign popped  = rdValid && rdReady;
    assign pushed  = wrValid && ((count < CW'(DEPTH)) || popped);
    assign dropped = wrValid && !pushed;

    always_comb begin
        nextCount = count;
        if (pushed && !popped)
            nextCount = count + CW'(1);
        else if (!pushed && popped)
            nextCount = count - CW'(1);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushed) wrPtr <= wrPtr + AW'(1);
            if (popped) rdPtr <= rdPtr + AW'(1);
            count <= nextCount;
        end
    end

    always_ff @(posedge clk) begin
        if (pushed) mem[wrPtr] <= wrData;
    end
endmodule

// File: rtl/gaussian_wr_buffer.sv
// Decouples gaussian kernel output from the requestor write path and tracks
// per-frame line completion.
module gaussian_wr_buffer
    import gaussian_pkg::*;
#(
    parameter int DEPTH        = HC_WRBUF_DEPTH,
    parameter int AFULL_THRESH = HC_WRBUF_AFULL
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [511:0]           data_in,
    input  logic                   valid_in,
    output logic [511:0]           data_out,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    input  logic                   start,
    input  logic [31:0]            num_lines,
    output logic [31:0]            lines_done,
    output logic                   done,
    output logic                   overflow
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0] nextCount;
    logic          pushed, popped, dropped;
    t_wrbuf_state  state, stateNext;
    logic [31:0]   numLinesQ;
    logic          startAcc, lineStep;

    hc_sync_fifo #(.WIDTH(HC_LINE_WIDTH), .DEPTH(DEPTH)) uFifo (
        .clk       (clk),
        .reset     (reset),
        .wrData    (data_in),
        .wrValid   (valid_in),
        .rdReady   (ready_in),
        .rdData    (data_out),
        .rdValid   (valid_out),
        .count     (count),
        .nextCount (nextCount),
        .pushed    (pushed),
        .popped    (popped),
        .dropped   (dropped)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        startAcc  = 1'b0;
        lineStep  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    startAcc  = 1'b1;
                    stateNext = (num_lines == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (popped) begin
                    lineStep = 1'b1;
                    if (lines_done + 32'd1 == numLinesQ) stateNext = DONE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // A drop coinciding with a frame start still counts as a drop in the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            numLinesQ   <= '0;
            lines_done  <= '0;
            overflow    <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (startAcc) begin
                numLinesQ  <= num_lines;
                lines_done <= '0;
            end else if (lineStep) begin
                lines_done <= lines_done + 32'd1;
            end
            overflow    <= (startAcc ? 1'b0 : overflow) | dropped;
            almost_full <= (nextCount >= CW'(AFULL_THRESH));
        end
    end

    assign done = (state == DONE);
endmodule
